idct8_stream: RTL and testbench

Parametrised 8-point 1-D inverse DCT with a ready/valid stream interface. It is the next-generation row/column engine for the JPEG decoder IDCT stage. It adds several features over the fixed-width version:
- generic lane widths and coefficient precision;
- full backpressure;
- a per-beat shift amount, rounding and clip mode carried through the pipeline;
- a last-flag passthrough and a saturation indicator.

It sits between the dequantiser/transpose buffer and the output level-shift logic. It is instantiated twice (row pass, column pass).

---
 rtl/idct8_stream.sv | 171 +++++++++++++++++
 tb/tb_idct8_stream.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct8_stream.sv
// 8-point 1-D inverse DCT, 5-register pipeline with global-enable backpressure.
// Even/odd decomposition over a constant coefficient table rounded from CF.
module idct8_stream #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 32,
    parameter int CF      = 8,
    parameter int CLIP_LO = -128,
    parameter int CLIP_HI = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*IN_W-1:0]  data_in,
    input  logic [4:0]         shift_amount,
    input  logic               round_en,
    input  logic               clip_en,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [8*OUT_W-1:0] data_out,
    output logic               m_last,
    output logic               sat_flag
);
    localparam int ACC_W = IN_W + CF + 4;
    localparam int RW    = ACC_W + 33;

    // cos(a*pi/16) scaled by 2^30, rounded half-up down to CF fraction bits
    function automatic int cos_mag(input int a);
        int c;
        case (a)
            0:       c = 1073741824;
            1:       c = 1053110176;
            2:       c = 992008094;
            3:       c = 892783698;
            4:       c = 759250125;
            5:       c = 596538995;
            6:       c = 410903207;
            7:       c = 209476638;
            default: c = 0;
        endcase
        return (c + (1 << (29 - CF))) >>> (30 - CF);
    endfunction

    function automatic int k_coef(input int u, input int x);
        int a;
        int sgn;
        if (u == 0) return cos_mag(4);
        a   = ((2 * x + 1) * u) % 32;
        sgn = 1;
        if (a > 16) a = 32 - a;
        if (a > 8) begin
            a   = 16 - a;
            sgn = -1;
        end
        return sgn * cos_mag(a);
    endfunction

    typedef struct packed {
        logic       last;
        logic       clip;
        logic       rnd;
        logic [4:0] sh;
    } sb_t;

    logic en;
    logic v0, v1, v2, v3;
    sb_t  sb0, sb1, sb2, sb3;

    logic [8*IN_W-1:0]       d0;
    logic signed [ACC_W-1:0] prod [8][4];
    logic signed [ACC_W-1:0] p1   [8][4];
    logic signed [ACC_W-1:0] e_c  [4];
    logic signed [ACC_W-1:0] o_c  [4];
    logic signed [ACC_W-1:0] e2   [4];
    logic signed [ACC_W-1:0] o2   [4];
    logic signed [ACC_W-1:0] a_c  [8];
    logic signed [ACC_W-1:0] a3   [8];

    logic [5:0]          s_tot;
    logic signed [RW-1:0] bias;
    logic signed [RW-1:0] r;
    logic [8*OUT_W-1:0]  out_c;
    logic                sat_c;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    for (genvar u = 0; u < 8; u++) begin : g_u
        logic signed [IN_W-1:0] lane;
        assign lane = d0[u*IN_W +: IN_W];
        for (genvar x = 0; x < 4; x++) begin : g_x
            localparam logic signed [ACC_W-1:0] KC = ACC_W'(k_coef(u, x));
            assign prod[u][x] = KC * ACC_W'(lane);
        end
    end

    always_comb begin
        for (int x = 0; x < 4; x++) begin
            e_c[x] = p1[0][x] + p1[2][x] + p1[4][x] + p1[6][x];
            o_c[x] = p1[1][x] + p1[3][x] + p1[5][x] + p1[7][x];
        end
    end

    always_comb begin
        for (int x = 0; x < 4; x++) begin
            a_c[x]     = e2[x] + o2[x];
            a_c[7 - x] = e2[x] - o2[x];
        end
    end

    always_comb begin
        s_tot = 6'(CF) + {1'b0, sb3.sh};
        bias  = '0;
        r     = '0;
        out_c = '0;
        sat_c = 1'b0;
        if (sb3.rnd) bias = (RW'(1) << s_tot) >> 1;
        for (int x = 0; x < 8; x++) begin
            r = (RW'(a3[x]) + bias) >>> s_tot;
            if (!sb3.clip) begin
                out_c[x*OUT_W +: OUT_W] = OUT_W'(r);
            end else if (r > RW'(CLIP_HI)) begin
                out_c[x*OUT_W +: OUT_W] = OUT_W'(CLIP_HI);
                sat_c = 1'b1;
            end else if (r < RW'(CLIP_LO)) begin
                out_c[x*OUT_W +: OUT_W] = OUT_W'(CLIP_LO);
                sat_c = 1'b1;
            end else begin
                out_c[x*OUT_W +: OUT_W] = OUT_W'(r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            sat_flag <= 1'b0;
            data_out <= '0;
        end else if (en) begin
            v0       <= s_valid;
            v1       <= v0;
            v2       <= v1;
            v3       <= v2;
            m_valid  <= v3;
            m_last   <= v3 && sb3.last;
            sat_flag <= v3 && sat_c;
            data_out <= out_c;
        end
    end

    // Datapath needs no reset: the valid chain qualifies it.
    always_ff @(posedge clk) begin
        if (en) begin
            d0  <= data_in;
            sb0 <= '{last: s_last, clip: clip_en, rnd: round_en, sh: shift_amount};
            p1  <= prod;
            sb1 <= sb0;
            e2  <= e_c;
            o2  <= o_c;
            sb2 <= sb1;
            a3  <= a_c;
            sb3 <= sb2;
        end
    end
endmodule

// File: tb/tb_idct8_stream.sv
// Directed self-checking bench for idct8_stream at default parameters.
// Expected lane values are hand-derived from the CF=8 coefficient table.
`timescale 1ns/1ps
module tb_idct8_stream;
    localparam int IN_W  = 32;
    localparam int OUT_W = 32;

    typedef logic [8*IN_W-1:0]  din_t;
    typedef logic [8*OUT_W-1:0] dout_t;
    typedef int vec_t [8];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    din_t       data_in = '0;
    logic [4:0] shift_amount = '0;
    logic       round_en = 1'b0;
    logic       clip_en = 1'b0;
    logic       s_last = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    dout_t      data_out;
    logic       m_last;
    logic       sat_flag;

    int checks = 0;
    int errors = 0;

    idct8_stream dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
        .shift_amount(shift_amount), .round_en(round_en),
        .clip_en(clip_en), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
        .m_last(m_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    function automatic din_t pack_in(input vec_t v);
        din_t d;
        for (int i = 0; i < 8; i++) d[i*IN_W +: IN_W] = IN_W'(v[i]);
        return d;
    endfunction

    function automatic dout_t pack_out(input vec_t v);
        dout_t d;
        for (int i = 0; i < 8; i++) d[i*OUT_W +: OUT_W] = OUT_W'(v[i]);
        return d;
    endfunction

    function automatic dout_t splat(input int v);
        dout_t d;
        for (int i = 0; i < 8; i++) d[i*OUT_W +: OUT_W] = OUT_W'(v);
        return d;
    endfunction

    function automatic din_t dc_in(input int v);
        vec_t t;
        t = '{default: 0};
        t[0] = v;
        return pack_in(t);
    endfunction

    // Single beat into an empty pipe; returns output and cycles to m_valid
    task automatic run_one(input din_t d, input logic [4:0] sh,
                           input logic rnd, input logic clip, input logic last,
                           output dout_t q, output logic ql, output logic qs,
                           output int lat);
        data_in = d;
        shift_amount = sh;
        round_en = rnd;
        clip_en = clip;
        s_last = last;
        m_ready = 1'b1;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        q = data_out;
        ql = m_last;
        qs = sat_flag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid);
        end
        checks++;
        if (data_out !== '0) begin
            errors++; $display("FAIL reset_data got %h exp 0", data_out);
        end
        checks++;
        if (m_last !== 1'b0) begin
            errors++; $display("FAIL reset_m_last got %b exp 0", m_last);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++; $display("FAIL reset_sat got %b exp 0", sat_flag);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dc;
        dout_t q;
        logic ql, qs;
        int lat;
        run_one(dc_in(1000), 5'd0, 1'b0, 1'b0, 1'b1, q, ql, qs, lat);
        checks++;
        if (q !== splat(707)) begin
            errors++; $display("FAIL dc_data got %h exp %h", q, splat(707));
        end
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL dc_latency got %0d exp 4", lat);
        end
        checks++;
        if (ql !== 1'b1) begin
            errors++; $display("FAIL dc_last got %b exp 1", ql);
        end
        checks++;
        if (qs !== 1'b0) begin
            errors++; $display("FAIL dc_sat got %b exp 0", qs);
        end
    endtask

    task automatic test_lanes;
        vec_t tin [5];
        vec_t texp [5];
        dout_t q;
        logic ql, qs;
        int lat;
        tin[0]  = '{0, 256, 0, 0, 0, 0, 0, 0};
        texp[0] = '{251, 213, 142, 50, -50, -142, -213, -251};
        tin[1]  = '{256, 0, 256, 0, 0, 0, 0, 0};
        texp[1] = '{418, 279, 83, -56, -56, 83, 279, 418};
        tin[2]  = '{0, 0, 0, 256, 0, 0, 256, 0};
        texp[2] = '{311, -287, -14, -240, 44, 488, -187, -115};
        tin[3]  = '{0, 0, 0, 0, 0, 256, 0, 256};
        texp[3] = '{192, -393, 263, -38, 38, -263, 393, -192};
        tin[4]  = '{0, 0, 0, 0, 256, 0, 0, 0};
        texp[4] = '{181, -181, -181, 181, 181, -181, -181, 181};
        for (int i = 0; i < 5; i++) begin
            run_one(pack_in(tin[i]), 5'd0, 1'b0, 1'b0, 1'b0, q, ql, qs, lat);
            checks++;
            if (q !== pack_out(texp[i])) begin
                errors++;
                $display("FAIL lanes_%0d got %h exp %h", i, q, pack_out(texp[i]));
            end
        end
    endtask

    task automatic test_round_clip;
        int t_in  [10] = '{-1000, -1000, 1000, -1000, 100, 180, -181, 1000, 1000, -1000};
        int t_sh  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 31};
        int t_rnd [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        int t_clp [10] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
        int t_exp [10] = '{-708, -707, 127, -128, 70, 127, -128, 353, 354, -1};
        int t_sat [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        dout_t q;
        logic ql, qs, lst;
        int lat;
        for (int i = 0; i < 10; i++) begin
            lst = (i % 2) == 1;
            run_one(dc_in(t_in[i]), 5'(t_sh[i]), t_rnd[i] != 0, t_clp[i] != 0,
                    lst, q, ql, qs, lat);
            checks++;
            if (q !== splat(t_exp[i])) begin
                errors++;
                $display("FAIL rc_data_%0d got %h exp %h", i, q, splat(t_exp[i]));
            end
            checks++;
            if (qs !== (t_sat[i] != 0)) begin
                errors++; $display("FAIL rc_sat_%0d got %b exp %0d", i, qs, t_sat[i]);
            end
            checks++;
            if (ql !== lst) begin
                errors++; $display("FAIL rc_last_%0d got %b exp %b", i, ql, lst);
            end
        end
    endtask

    task automatic test_back_to_back;
        int seen = 0;
        int c0 = -1;
        int c1 = -1;
        dout_t d0 = '0;
        dout_t d1 = '0;
        logic l1 = 1'b0;
        m_ready = 1'b1;
        round_en = 1'b0;
        clip_en = 1'b0;
        data_in = dc_in(1000);
        shift_amount = 5'd0;
        s_last = 1'b0;
        s_valid = 1'b1;
        @(posedge clk); #1;
        shift_amount = 5'd3;
        s_last = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int c = 1; c < 12; c++) begin
            if (m_valid) begin
                if (seen == 0) begin
                    c0 = c; d0 = data_out;
                end else if (seen == 1) begin
                    c1 = c; d1 = data_out; l1 = m_last;
                end
                seen++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 2) begin
            errors++; $display("FAIL b2b_count got %0d exp 2", seen);
        end
        checks++;
        if (c0 != 4 || c1 != 5) begin
            errors++; $display("FAIL b2b_timing got %0d,%0d exp 4,5", c0, c1);
        end
        checks++;
        if (d0 !== splat(707)) begin
            errors++; $display("FAIL b2b_first got %h exp %h", d0, splat(707));
        end
        checks++;
        if (d1 !== splat(88)) begin
            errors++; $display("FAIL b2b_second got %h exp %h", d1, splat(88));
        end
        checks++;
        if (l1 !== 1'b1) begin
            errors++; $display("FAIL b2b_last got %b exp 1", l1);
        end
    endtask

    task automatic test_stall;
        int sent = 0;
        int got = 0;
        int stalls = 0;
        int extra = 0;
        logic prev_stall = 1'b0;
        logic acc;
        dout_t held = '0;
        shift_amount = 5'd0;
        round_en = 1'b0;
        clip_en = 1'b0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            m_ready = !(c >= 5 && c <= 7);
            s_valid = sent < 6;
            data_in = dc_in(256 * (sent + 1));
            s_last = sent == 5;
            #1;
            checks++;
            if (s_ready !== !(m_valid && !m_ready)) begin
                errors++; $display("FAIL stall_s_ready_c%0d got %b", c, s_ready);
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || data_out !== held) begin
                    errors++;
                    $display("FAIL stall_hold_c%0d got %h exp %h", c, data_out, held);
                end
            end
            prev_stall = m_valid && !m_ready;
            if (prev_stall) stalls++;
            held = data_out;
            if (m_valid && m_ready) begin
                checks++;
                if (data_out !== splat(181 * (got + 1)) || m_last !== (got == 5)) begin
                    errors++;
                    $display("FAIL stall_beat_%0d got %h/%b exp %h", got, data_out,
                             m_last, splat(181 * (got + 1)));
                end
                got++;
            end
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m_valid) extra++;
            @(posedge clk); #1;
        end
        checks++;
        if (got != 6) begin
            errors++; $display("FAIL stall_delivered got %0d exp 6", got);
        end
        checks++;
        if (stalls != 3) begin
            errors++; $display("FAIL stall_cycles got %0d exp 3", stalls);
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL stall_duplicates got %0d exp 0", extra);
        end
    endtask

    task automatic test_reset_flight;
        int emitted = 0;
        dout_t q;
        logic ql, qs;
        int lat;
        m_ready = 1'b1;
        shift_amount = 5'd0;
        round_en = 1'b0;
        clip_en = 1'b0;
        s_last = 1'b1;
        data_in = dc_in(512);
        s_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL flight_m_valid got %b exp 0", m_valid);
        end
        for (int c = 0; c < 10; c++) begin
            if (m_valid) emitted++;
            @(posedge clk); #1;
        end
        checks++;
        if (emitted != 0) begin
            errors++; $display("FAIL flight_emitted got %0d exp 0", emitted);
        end
        run_one(dc_in(768), 5'd0, 1'b0, 1'b0, 1'b0, q, ql, qs, lat);
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL flight_latency got %0d exp 4", lat);
        end
        checks++;
        if (q !== splat(543)) begin
            errors++; $display("FAIL flight_data got %h exp %h", q, splat(543));
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_lanes();
        test_round_clip();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
